// File: rtl/rnn_cell_fx.sv
// Fixed-point recurrent cell: h_t = act(U*x_t + W*h_{t-1}), y_t = V*h_t on one shared MAC.
// Define RNN_LEAKY_RELU_EN to swap ReLU for a leaky ReLU (negative slope 1/8).
module rnn_cell_fx #(
  parameter int DW   = 16,
  parameter int FRAC = 8,
  parameter int N    = 3,
  parameter int T    = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid_u,
  input  logic          in_valid_w,
  input  logic          in_valid_v,
  input  logic          in_valid_x,
  input  logic [DW-1:0] weight_u,
  input  logic [DW-1:0] weight_w,
  input  logic [DW-1:0] weight_v,
  input  logic [DW-1:0] data_x,
  output logic          out_valid,
  output logic [DW-1:0] out
);

  localparam int NN  = N * N;
  localparam int TN  = T * N;
  localparam int ACW = 2 * DW + $clog2(2 * N) + 1;
  localparam int MAW = (NN > 1) ? $clog2(NN) : 1;
  localparam int XAW = (TN > 1) ? $clog2(TN) : 1;
  localparam int HAW = (N > 1) ? $clog2(N) : 1;
  localparam int TW  = (T > 1) ? $clog2(T) : 1;
  localparam int MCW = $clog2(NN + 1);
  localparam int XCW = $clog2(TN + 1);
  localparam int KW  = $clog2(2 * N + 1);

  typedef enum logic [1:0] {LOAD, CALC_H, CALC_Y, OUT} state_t;
  state_t state, next_state;

  logic signed [DW-1:0] u_mem [NN];
  logic signed [DW-1:0] w_mem [NN];
  logic signed [DW-1:0] v_mem [NN];
  logic signed [DW-1:0] x_mem [TN];
  logic signed [DW-1:0] h_prev [N];
  logic signed [DW-1:0] h_new [N];
  logic signed [DW-1:0] y_buf [TN];

  logic [MCW-1:0] cnt_u, cnt_w, cnt_v;
  logic [XCW-1:0] cnt_x;
  logic [HAW-1:0] row;
  logic [KW-1:0]  col;
  logic [TW-1:0]  step;
  logic [XAW-1:0] out_idx;
  logic signed [ACW-1:0] acc;

  int row_i, col_i, step_i;
  assign row_i  = int'(row);
  assign col_i  = int'(col);
  assign step_i = int'(step);

  logic take_u, take_w, take_v, take_x, load_done;
  assign take_u = (state == LOAD) && in_valid_u && (cnt_u != MCW'(NN));
  assign take_w = (state == LOAD) && in_valid_w && (cnt_w != MCW'(NN));
  assign take_v = (state == LOAD) && in_valid_v && (cnt_v != MCW'(NN));
  assign take_x = (state == LOAD) && in_valid_x && (cnt_x != XCW'(TN));
  assign load_done = (cnt_u == MCW'(NN)) && (cnt_w == MCW'(NN)) &&
                     (cnt_v == MCW'(NN)) && (cnt_x == XCW'(TN));

  logic h_mac, y_mac, last_row, last_step, last_out;
  assign h_mac     = (state == CALC_H) && (col_i < 2 * N);
  assign y_mac     = (state == CALC_Y) && (col_i < N);
  assign last_row  = (row_i == N - 1);
  assign last_step = (step_i == T - 1);
  assign last_out  = (int'(out_idx) == TN - 1);

  // Operand select: U*x then W*h_prev for hidden rows, V*h_new for output rows.
  logic signed [DW-1:0] op_a, op_b;
  always_comb begin
    op_a = '0;
    op_b = '0;
    if (h_mac) begin
      if (col_i < N) begin
        op_a = u_mem[MAW'(row_i * N + col_i)];
        op_b = x_mem[XAW'(step_i * N + col_i)];
      end else begin
        op_a = w_mem[MAW'(row_i * N + col_i - N)];
        op_b = h_prev[HAW'(col_i - N)];
      end
    end else if (y_mac) begin
      op_a = v_mem[MAW'(row_i * N + col_i)];
      op_b = h_new[HAW'(col_i)];
    end
  end

  logic signed [2*DW-1:0] prod;
  logic signed [ACW-1:0]  prod_ext, shifted;
  logic signed [DW-1:0]   sat_val, act_val;
  logic                   fits;

  always_comb begin
    prod     = op_a * op_b;
    prod_ext = ACW'(prod);
    shifted  = acc >>> FRAC;
    fits     = (&shifted[ACW-1:DW-1]) | ~(|shifted[ACW-1:DW-1]);
    if (fits)
      sat_val = shifted[DW-1:0];
    else if (shifted[ACW-1])
      sat_val = {1'b1, {(DW-1){1'b0}}};
    else
      sat_val = {1'b0, {(DW-1){1'b1}}};
`ifdef RNN_LEAKY_RELU_EN
    act_val = sat_val[DW-1] ? (sat_val >>> 3) : sat_val;
`else
    act_val = sat_val[DW-1] ? '0 : sat_val;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) state <= LOAD;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      LOAD:   if (load_done) next_state = CALC_H;
      CALC_H: if (col_i == 2 * N && last_row) next_state = CALC_Y;
      CALC_Y: if (col_i == N && last_row) next_state = last_step ? OUT : CALC_H;
      OUT:    if (last_out) next_state = LOAD;
      default: next_state = LOAD;
    endcase
  end

  // Operand storage is reloaded every job, so it carries no reset.
  always_ff @(posedge clk) begin
    if (take_u) u_mem[MAW'(cnt_u)] <= weight_u;
    if (take_w) w_mem[MAW'(cnt_w)] <= weight_w;
    if (take_v) v_mem[MAW'(cnt_v)] <= weight_v;
    if (take_x) x_mem[XAW'(cnt_x)] <= data_x;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_u   <= '0;
      cnt_w   <= '0;
      cnt_v   <= '0;
      cnt_x   <= '0;
      row     <= '0;
      col     <= '0;
      step    <= '0;
      out_idx <= '0;
      acc     <= '0;
      for (int i = 0; i < N; i++) begin
        h_prev[i] <= '0;
        h_new[i]  <= '0;
      end
      for (int i = 0; i < TN; i++) y_buf[i] <= '0;
    end else begin
      if (take_u) cnt_u <= cnt_u + 1'b1;
      if (take_w) cnt_w <= cnt_w + 1'b1;
      if (take_v) cnt_v <= cnt_v + 1'b1;
      if (take_x) cnt_x <= cnt_x + 1'b1;
      case (state)
        LOAD: begin
          for (int i = 0; i < N; i++) h_prev[i] <= '0;
        end
        CALC_H: begin
          if (h_mac) begin
            acc <= acc + prod_ext;
            col <= col + 1'b1;
          end else begin
            h_new[row] <= act_val;
            acc <= '0;
            col <= '0;
            row <= last_row ? '0 : row + 1'b1;
          end
        end
        CALC_Y: begin
          if (y_mac) begin
            acc <= acc + prod_ext;
            col <= col + 1'b1;
          end else begin
            y_buf[XAW'(step_i * N + row_i)] <= sat_val;
            acc <= '0;
            col <= '0;
            if (last_row) begin
              // h_t becomes the recurrent operand only once all of y_t is done.
              row <= '0;
              for (int i = 0; i < N; i++) h_prev[i] <= h_new[i];
              step <= last_step ? '0 : step + 1'b1;
            end else begin
              row <= row + 1'b1;
            end
          end
        end
        OUT: begin
          if (last_out) begin
            out_idx <= '0;
            cnt_u   <= '0;
            cnt_w   <= '0;
            cnt_v   <= '0;
            cnt_x   <= '0;
          end else begin
            out_idx <= out_idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    out_valid = (state == OUT);
    out       = out_valid ? y_buf[out_idx] : '0;
  end

endmodule

// File: tb/tb_rnn_cell_fx.sv
// Testbench for rnn_cell_fx: directed and randomized jobs checked against a plain-arithmetic model.
module tb_rnn_cell_fx;

  localparam int DW   = 16;
  localparam int FRAC = 8;
  localparam int N    = 3;
  localparam int T    = 3;
  localparam int NN   = N * N;
  localparam int TN   = T * N;
  localparam int C    = T * (3 * N * N + 2 * N);

  logic clk = 1'b0;
  logic rst;
  logic in_valid_u, in_valid_w, in_valid_v, in_valid_x;
  logic [DW-1:0] weight_u, weight_w, weight_v, data_x;
  logic out_valid;
  logic [DW-1:0] out;

  rnn_cell_fx #(.DW(DW), .FRAC(FRAC), .N(N), .T(T)) dut (
    .clk(clk), .rst(rst),
    .in_valid_u(in_valid_u), .in_valid_w(in_valid_w),
    .in_valid_v(in_valid_v), .in_valid_x(in_valid_x),
    .weight_u(weight_u), .weight_w(weight_w),
    .weight_v(weight_v), .data_x(data_x),
    .out_valid(out_valid), .out(out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;
  int u [NN];
  int w [NN];
  int v [NN];
  int x [TN];
  int exp_y [TN];
  int last_cyc;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic signed [31:0] obs,
                             input logic signed [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic int sat(input longint val);
    longint hi = (longint'(1) <<< (DW - 1)) - 1;
    longint lo = -(longint'(1) <<< (DW - 1));
    if (val > hi) return int'(hi);
    if (val < lo) return int'(lo);
    return int'(val);
  endfunction

  function automatic int act(input int val);
`ifdef RNN_LEAKY_RELU_EN
    return (val < 0) ? (val >>> 3) : val;
`else
    return (val < 0) ? 0 : val;
`endif
  endfunction

  // Reference: straight matrix-vector recurrence with wide integers.
  task automatic runModel();
    int hp [N];
    int hn [N];
    longint acc;
    for (int i = 0; i < N; i++) hp[i] = 0;
    for (int t = 0; t < T; t++) begin
      for (int i = 0; i < N; i++) begin
        acc = 0;
        for (int j = 0; j < N; j++)
          acc += longint'(u[i*N+j]) * x[t*N+j] + longint'(w[i*N+j]) * hp[j];
        hn[i] = act(sat(acc >>> FRAC));
      end
      for (int i = 0; i < N; i++) begin
        acc = 0;
        for (int j = 0; j < N; j++) acc += longint'(v[i*N+j]) * hn[j];
        exp_y[t*N+i] = sat(acc >>> FRAC);
      end
      for (int i = 0; i < N; i++) hp[i] = hn[i];
    end
  endtask

  task automatic setCase(input int ud, input int wd, input int vd,
                         input int x0, input int x1, input int x2);
    int xs [3];
    xs[0] = x0; xs[1] = x1; xs[2] = x2;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        u[i*N+j] = (i == j) ? ud : 0;
        w[i*N+j] = (i == j) ? wd : 0;
        v[i*N+j] = (i == j) ? vd : 0;
      end
    for (int k = 0; k < TN; k++) x[k] = xs[k % N];
    runModel();
  endtask

  task automatic randomCase(input int mag);
    for (int k = 0; k < NN; k++) begin
      u[k] = int'($urandom_range(0, 2 * mag)) - mag;
      w[k] = int'($urandom_range(0, 2 * mag)) - mag;
      v[k] = int'($urandom_range(0, 2 * mag)) - mag;
    end
    for (int k = 0; k < TN; k++) x[k] = int'($urandom_range(0, 2 * mag)) - mag;
    runModel();
  endtask

  // mode 0: all streams with random gaps; 1: u first then the rest; 2: lockstep.
  task automatic applyStimulus(input int mode);
    int iu = 0, iw = 0, iv = 0, ix = 0;
    bit gu, gw, gv, gx;
    while (iu < NN || iw < NN || iv < NN || ix < TN) begin
      case (mode)
        1: begin
          gu = 1'b1;
          gw = (iu >= NN) && ($urandom_range(0, 2) != 0);
          gv = (iu >= NN) && ($urandom_range(0, 2) != 0);
          gx = (iu >= NN) && ($urandom_range(0, 2) != 0);
        end
        2: begin gu = 1'b1; gw = 1'b1; gv = 1'b1; gx = 1'b1; end
        default: begin
          gu = ($urandom_range(0, 2) != 0);
          gw = ($urandom_range(0, 2) != 0);
          gv = ($urandom_range(0, 2) != 0);
          gx = ($urandom_range(0, 2) != 0);
        end
      endcase
      in_valid_u = gu; in_valid_w = gw; in_valid_v = gv; in_valid_x = gx;
      weight_u = (iu < NN) ? DW'(u[iu]) : DW'($urandom);
      weight_w = (iw < NN) ? DW'(w[iw]) : DW'($urandom);
      weight_v = (iv < NN) ? DW'(v[iv]) : DW'($urandom);
      data_x   = (ix < TN) ? DW'(x[ix]) : DW'($urandom);
      if ((gu && iu < NN) || (gw && iw < NN) || (gv && iv < NN) || (gx && ix < TN))
        last_cyc = cyc;
      if (gu && iu < NN) iu++;
      if (gw && iw < NN) iw++;
      if (gv && iv < NN) iv++;
      if (gx && ix < TN) ix++;
      tick();
    end
    in_valid_u = 1'b0; in_valid_w = 1'b0; in_valid_v = 1'b0; in_valid_x = 1'b0;
  endtask

  task automatic collectOutputs(input string tag);
    int waited = 0;
    while (out_valid !== 1'b1 && waited < 400) begin
      tick();
      waited++;
    end
    checkOutput({tag, "_first_cycle"}, cyc, last_cyc + C + 2);
    for (int k = 0; k < TN; k++) begin
      checkOutput($sformatf("%s_valid%0d", tag, k), out_valid, 1);
      checkOutput($sformatf("%s_y%0d", tag, k), $signed(out), exp_y[k]);
      tick();
    end
    checkOutput({tag, "_valid_after"}, out_valid, 0);
    checkOutput({tag, "_out_after"}, $signed(out), 0);
  endtask

  initial begin
    int seen;
    int waited;
    rst = 1'b1;
    in_valid_u = 1'b0; in_valid_w = 1'b0; in_valid_v = 1'b0; in_valid_x = 1'b0;
    weight_u = '0; weight_w = '0; weight_v = '0; data_x = '0;
    repeat (3) tick();
    checkOutput("reset_valid", out_valid, 0);
    checkOutput("reset_out", $signed(out), 0);
    rst = 1'b0;
    tick();

    setCase(256, 0, 256, 256, -512, 128);
    applyStimulus(0);
    collectOutputs("identity");

    // Next job starts the very cycle after the last out_valid.
    setCase(256, 256, 256, 256, 256, 256);
    applyStimulus(2);
    collectOutputs("recurrence");

    setCase(32512, 0, 256, 32512, 32512, 32512);
    applyStimulus(0);
    collectOutputs("sat_pos");

    setCase(32512, 0, -512, 32512, 32512, 32512);
    applyStimulus(0);
    collectOutputs("sat_neg");

    setCase(256, 0, 256, 256, -512, 128);
    applyStimulus(1);
    for (int k = 0; k < 5; k++) begin
      in_valid_x = 1'b1;
      data_x = DW'($urandom);
      tick();
    end
    in_valid_x = 1'b0;
    collectOutputs("ordering");

    // Reset while computing a hidden row.
    setCase(256, 256, 256, 256, 256, 256);
    applyStimulus(0);
    while (cyc < last_cyc + 40) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("rst_calc_valid", out_valid, 0);
    checkOutput("rst_calc_out", $signed(out), 0);
    seen = 0;
    for (int k = 0; k < 150; k++) begin
      if (out_valid !== 1'b0) seen++;
      tick();
    end
    checkOutput("rst_calc_quiet", seen, 0);

    // Reset in the middle of the output stream.
    setCase(256, 0, 256, 256, -512, 128);
    applyStimulus(0);
    waited = 0;
    while (out_valid !== 1'b1 && waited < 400) begin
      tick();
      waited++;
    end
    checkOutput("rst_out_reached", out_valid, 1);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_out_out", $signed(out), 0);
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      if (out_valid !== 1'b0) seen++;
      tick();
    end
    checkOutput("rst_out_quiet", seen, 0);

    setCase(256, 256, 256, 256, 256, 256);
    applyStimulus(0);
    collectOutputs("after_reset");

    setCase(256, 0, 256, -256, 512, -1024);
    applyStimulus(0);
    collectOutputs("negative");

    for (int r = 0; r < 3; r++) begin
      randomCase((r == 2) ? 32767 : 600);
      applyStimulus(r % 3);
      collectOutputs($sformatf("random%0d", r));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
